dpram_bist_ctrl: RTL and testbench

Built-in self-test controller for the 64 x 8 dual-port RAM (`dualportram`). It owns both RAM ports during a test and runs a four-element march: write through port 1, read through port 2 with pipelined write-back, then a final read through port 1. It reports pass/fail plus the first failing address and data. It sits between the RAM and a system-level test sequencer, which pulses `start` and samples `done` and `pass`.

---
 rtl/dpram_bist_pkg.sv | 9 +
 rtl/dpram_bist_cmp.sv | 34 +++
 rtl/dpram_bist_ctrl.sv | 107 ++++++++++
 tb/tb_dpram_bist_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dpram_bist_pkg.sv
// dpram_bist_pkg: shared states and default geometry for the dual-port RAM march BIST.
package dpram_bist_pkg;
    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, DONE} state_t;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;
    localparam logic [7:0] DEF_PATTERN = 8'h55;
    localparam int DEPTH = 2 ** DEF_ADDR_W;
    localparam int DONE_CYCLE = 4 * DEPTH + 4;
endpackage

// File: rtl/dpram_bist_cmp.sv
// dpram_bist_cmp: read-data compare with sticky first-fail capture and pass flag.
module dpram_bist_cmp
    import dpram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] expected,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);
    always_ff @(posedge clk) begin
        if (rst) begin
            pass <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (clr) begin
            pass <= 1'b1;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (en && pass && data != expected) begin
            pass <= 1'b0;
            fail_addr <= addr;
            fail_data <= data;
        end
    end
endmodule

// File: rtl/dpram_bist_ctrl.sv
// dpram_bist_ctrl: four-element march controller driving both ports of a dual-port RAM.
module dpram_bist_ctrl
    import dpram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] datain1,
    output logic [ADDR_W-1:0] addr1,
    output logic              we1,
    output logic [DATA_W-1:0] datain2,
    output logic [ADDR_W-1:0] addr2,
    output logic              we2,
    input  logic [DATA_W-1:0] dout1,
    input  logic [DATA_W-1:0] dout2
);
    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [ADDR_W-1:0] ZERO = '0;
    state_t state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n, cmp_addr, addr1_n, addr2_n;
    logic [DATA_W-1:0] datain1_n;
    logic drain, drain_n, asc, cmp_en, m12_n, we1_n;
    assign datain2 = '0;
    assign we2 = 1'b0;
    assign asc = state != M2;
    // The first cycle of a read element has no data back yet; the drain cycle catches the last read.
    assign cmp_en = (state == M1 || state == M2 || state == M3) && (drain || cnt != (asc ? ZERO : LAST));
    assign cmp_addr = drain ? cnt : asc ? cnt - 1'b1 : cnt + 1'b1;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        drain_n = drain;
        case (state)
            IDLE: if (start) begin
                state_n = M0;
                cnt_n = '0;
                drain_n = 1'b0;
            end
            M0: begin
                cnt_n = cnt + 1'b1;
                if (cnt == LAST) state_n = M1;
            end
            M1, M3: if (drain) begin
                state_n = state == M1 ? M2 : DONE;
                drain_n = 1'b0;
            end else if (cnt == LAST) drain_n = 1'b1;
            else cnt_n = cnt + 1'b1;
            M2: if (drain) begin
                state_n = M3;
                drain_n = 1'b0;
            end else if (cnt == ZERO) drain_n = 1'b1;
            else cnt_n = cnt - 1'b1;
            default: state_n = IDLE;
        endcase
    end
    // Port outputs are decoded from the next state so they register in step with it.
    // Write-back trails the port-2 read by one address; the drain read is steered away from it.
    assign m12_n = state_n == M1 || state_n == M2;
    assign we1_n = state_n == M0 || (m12_n && (drain_n || cnt_n != (state_n == M2 ? LAST : ZERO)));
    assign addr1_n = (m12_n && !drain_n) ? (state_n == M2 ? cnt_n + 1'b1 : cnt_n - 1'b1) : cnt_n;
    assign addr2_n = m12_n ? (drain_n ? ~cnt_n : cnt_n) : '0;
    assign datain1_n = (state_n == M0 || state_n == M2) ? PATTERN : state_n == M1 ? ~PATTERN : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            drain <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            we1 <= 1'b0;
            addr1 <= '0;
            addr2 <= '0;
            datain1 <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            drain <= drain_n;
            busy <= state_n inside {M0, M1, M2, M3};
            done <= state_n == DONE;
            we1 <= we1_n;
            addr1 <= addr1_n;
            addr2 <= addr2_n;
            datain1 <= datain1_n;
        end
    end
    dpram_bist_cmp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp (
        .clk(clk),
        .rst(rst),
        .clr(state == IDLE && start),
        .en(cmp_en),
        .expected(state == M2 ? ~PATTERN : PATTERN),
        .data(state == M3 ? dout1 : dout2),
        .addr(cmp_addr),
        .pass(pass),
        .fail_addr(fail_addr),
        .fail_data(fail_data)
    );
endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// tb_dpram_bist_ctrl: directed and random fault-injection runs against an abstract march model.
module tb_dpram_bist_ctrl;
    import dpram_bist_pkg::*;
    localparam logic [7:0] P = 8'h55;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, pass, we1, we2;
    logic [5:0] fail_addr, addr1, addr2;
    logic [7:0] fail_data, datain1, datain2, dout1, dout2;
    logic [7:0] mem [64];
    bit sa_en = 0, sa_one = 0, m3_en = 0;
    logic [5:0] sa_addr = '0;
    logic [7:0] sa_mask = '0;
    int n_cmp = 0, n_bad = 0;
    logic b1, p1;
    logic [5:0] fa1;
    logic [7:0] fd1;

    dpram_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .datain1(datain1), .addr1(addr1), .we1(we1),
        .datain2(datain2), .addr2(addr2), .we2(we2),
        .dout1(dout1), .dout2(dout2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [5:0] a, input logic [7:0] v);
        return (sa_en && a == sa_addr) ? (sa_one ? v | sa_mask : v & ~sa_mask) : v;
    endfunction

    always @(posedge clk) begin
        if (we1) mem[addr1] <= datain1;
        if (we2) mem[addr2] <= datain2;
        dout1 <= rd(addr1, mem[addr1]) & ((m3_en && busy && !we1 && addr1 == 6'h10) ? 8'hFE : 8'hFF);
        dout2 <= rd(addr2, mem[addr2]);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts a march in the current cycle and returns the cycle number at which done appears.
    task automatic run(output int cyc);
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        b1 = busy; p1 = pass; fa1 = fail_addr; fd1 = fail_data;
        while (!done && cyc < 600) begin
            tick;
            cyc++;
        end
    endtask

    task automatic model(output bit p, output logic [5:0] a, output logic [7:0] d);
        logic [7:0] img [64];
        logic [7:0] v;
        p = 1; a = '0; d = '0;
        for (int i = 0; i < 64; i++) img[i] = P;
        for (int e = 1; e <= 3; e++)
            for (int j = 0; j < 64; j++) begin
                int i;
                logic [7:0] want;
                i = (e == 2) ? 63 - j : j;
                want = (e == 2) ? ~P : P;
                v = rd(6'(i), img[i]);
                if (e == 3 && m3_en && i == 16) v[0] = 1'b0;
                if (p && v != want) begin p = 0; a = 6'(i); d = v; end
                if (e == 1) img[i] = ~P;
                if (e == 2) img[i] = P;
            end
    endtask

    initial begin
        int cyc, cyc2, ndone, first, bad;
        bit ep;
        logic [5:0] ea;
        logic [7:0] ed;
        tick; tick;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_fail_data", fail_data, 0);
        check("rst_we1", we1, 0);
        check("rst_addr1", addr1, 0);
        check("rst_addr2", addr2, 0);
        check("rst_datain1", datain1, 0);
        check("we2_tied", {we2, datain2}, 0);

        run(cyc);
        check("clean_busy_c1", b1, 1);
        check("clean_done_cycle", cyc, DONE_CYCLE);
        check("clean_busy_at_done", busy, 0);
        check("clean_pass", pass, 1);
        check("clean_fail_addr", fail_addr, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== P) bad++;
        check("clean_ram_image", bad, 0);
        tick;
        check("done_one_cycle", done, 0);

        sa_en = 1; sa_one = 1; sa_addr = 6'h2A; sa_mask = 8'h08;
        run(cyc);
        check("sa_done_cycle", cyc, DONE_CYCLE);
        check("sa_pass", pass, 0);
        check("sa_fail_addr", fail_addr, 6'h2A);
        check("sa_fail_data", fail_data, 8'h5D);
        tick;
        sa_en = 0; m3_en = 1;
        run(cyc);
        check("m3_pass", pass, 0);
        check("m3_fail_addr", fail_addr, 6'h10);
        check("m3_fail_data", fail_data, 8'h54);
        m3_en = 0;
        tick;

        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (99) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_we1", we1, 0);
        check("midrst_outs", {pass, fail_addr, fail_data, addr1, addr2, datain1, done}, 0);
        repeat (9) tick;
        run(cyc);
        check("midrst_done_cycle", 110 + cyc, 370);
        check("midrst_pass", pass, 1);
        tick;

        rst = 1'b1; start = 1'b1;
        tick;
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start", busy, 0);
        tick;

        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1; ndone = 0; first = 0;
        while (cyc < 600) begin
            if (done) begin
                ndone++;
                if (first == 0) first = cyc;
            end
            start = (cyc == 50 || cyc == 259);
            tick;
            cyc++;
        end
        start = 1'b0;
        check("multi_start_ndone", ndone, 1);
        check("multi_start_cycle", first, DONE_CYCLE);

        sa_en = 1; sa_one = 0; sa_addr = 6'h03; sa_mask = 8'h01;
        run(cyc);
        check("b2b_first_pass", pass, 0);
        sa_en = 0;
        tick;
        run(cyc2);
        check("b2b_clear_pass", p1, 1);
        check("b2b_clear_fail", {fa1, fd1}, 0);
        check("b2b_spacing", cyc2 + 1, DONE_CYCLE + 1);
        check("b2b_second_pass", pass, 1);
        tick;

        for (int r = 0; r < 8; r++) begin
            sa_en = $urandom_range(0, 3) != 0;
            sa_one = 1'($urandom);
            sa_addr = 6'($urandom);
            sa_mask = 8'h01 << $urandom_range(0, 7);
            m3_en = $urandom_range(0, 2) == 0;
            model(ep, ea, ed);
            run(cyc);
            check("rnd_done_cycle", cyc, DONE_CYCLE);
            check("rnd_pass", pass, ep);
            check("rnd_fail_addr", fail_addr, ea);
            check("rnd_fail_data", fail_data, ed);
            tick;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
